// File: rtl/i2s_transmitter.sv
// I2S serial output stage: accepts stereo pairs over valid/ready, buffers one
// pending pair, and shifts them MSB-first onto sd with the I2S one-bit delay.
module i2s_transmitter #(
    parameter int SR_WIDTH        = 32,
    parameter bit UNDERRUN_REPEAT = 1'b1
) (
    input  logic                sck,
    input  logic                reset,
    input  logic                ws,
    input  logic [SR_WIDTH-1:0] in_L,
    input  logic [SR_WIDTH-1:0] in_R,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                sd,
    output logic                frame_start,
    output logic                underrun,
    output logic [15:0]         underrun_count
);

    typedef enum logic {
        S_UNSYNCED = 1'b0,
        S_SYNCED   = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                ws_d;
    logic                pend_full;
    logic [SR_WIDTH-1:0] pend_l;
    logic [SR_WIDTH-1:0] pend_r;
    logic [SR_WIDTH-1:0] act_l;
    logic [SR_WIDTH-1:0] act_r;
    logic [SR_WIDTH-1:0] shreg;
    logic                left_edge;
    logic                right_edge;
    logic                accept;
    logic                load_left;
    logic                load_right;

    assign in_ready = ~pend_full;

    // The first left edge both synchronises and loads, so no partial word is sent.
    always_comb begin
        left_edge  = ws_d & ~ws;
        right_edge = ~ws_d & ws;
        accept     = in_valid & ~pend_full;
        state_next = state;
        load_left  = 1'b0;
        load_right = 1'b0;
        case (state)
            S_UNSYNCED: begin
                if (left_edge) begin
                    state_next = S_SYNCED;
                    load_left  = 1'b1;
                end
            end
            S_SYNCED: begin
                load_left  = left_edge;
                load_right = right_edge;
            end
            default: state_next = S_UNSYNCED;
        endcase
    end

    always_ff @(posedge sck or posedge reset) begin
        if (reset) begin
            state <= S_UNSYNCED;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every register here, including the sample buffers, is reset so that an
    // asynchronous reset mid-word leaves nothing stale to be replayed later.
    always_ff @(posedge sck or posedge reset) begin
        if (reset) begin
            ws_d           <= 1'b0;
            pend_full      <= 1'b0;
            pend_l         <= '0;
            pend_r         <= '0;
            act_l          <= '0;
            act_r          <= '0;
            shreg          <= '0;
            frame_start    <= 1'b0;
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else begin
            ws_d        <= ws;
            frame_start <= load_left;
            underrun    <= load_left & ~pend_full;

            if (accept) begin
                pend_l <= in_L;
                pend_r <= in_R;
            end

            // A same-edge accept wins: the transfer below still reads the old pend_*.
            if (accept) begin
                pend_full <= 1'b1;
            end else if (load_left) begin
                pend_full <= 1'b0;
            end

            if (load_left) begin
                if (pend_full) begin
                    act_l <= pend_l;
                    act_r <= pend_r;
                    shreg <= pend_l;
                end else begin
                    if (underrun_count != 16'hFFFF) begin
                        underrun_count <= underrun_count + 16'd1;
                    end
                    if (UNDERRUN_REPEAT) begin
                        shreg <= act_l;
                    end else begin
                        shreg <= '0;
                        act_l <= '0;
                        act_r <= '0;
                    end
                end
            end else if (load_right) begin
                shreg <= act_r;
            end else begin
                shreg <= {shreg[SR_WIDTH-2:0], 1'b0};
            end
        end
    end

    // sd launches on the falling edge, half a bit after the rising-edge load.
    always_ff @(negedge sck or posedge reset) begin
        if (reset) begin
            sd <= 1'b0;
        end else begin
            sd <= shreg[SR_WIDTH-1];
        end
    end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter: one repeat-on-underrun instance and one
// zero-fill instance share the same ws/sck and handshake stimulus.
module tb_i2s_transmitter;

    localparam logic [31:0] A_L = 32'hA5A5_0001;
    localparam logic [31:0] A_R = 32'h8000_FFFF;
    localparam logic [31:0] P1L = 32'h1234_5678;
    localparam logic [31:0] P1R = 32'h9ABC_DEF0;
    localparam logic [31:0] P2L = 32'h0F0F_0F0F;
    localparam logic [31:0] P2R = 32'hF0F0_F0F0;
    localparam logic [31:0] P3L = 32'hFFFF_0001;
    localparam logic [31:0] P3R = 32'h7FFF_FFFE;

    logic        sck = 1'b0;
    logic        reset;
    logic        ws;
    logic [31:0] in_L;
    logic [31:0] in_R;
    logic        in_valid;
    logic        in_ready, sd, frame_start, underrun;
    logic [15:0] underrun_count;
    logic        in_ready0, sd0, frame_start0, underrun0;
    logic [15:0] underrun_count0;

    logic [63:0] hist  = '0;
    logic [63:0] hist0 = '0;
    int          fs_cnt = 0;
    int          ur_cnt = 0;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 sck = ~sck;

    i2s_transmitter #(.SR_WIDTH(32), .UNDERRUN_REPEAT(1'b1)) dut (
        .sck(sck), .reset(reset), .ws(ws), .in_L(in_L), .in_R(in_R),
        .in_valid(in_valid), .in_ready(in_ready), .sd(sd),
        .frame_start(frame_start), .underrun(underrun),
        .underrun_count(underrun_count)
    );

    i2s_transmitter #(.SR_WIDTH(32), .UNDERRUN_REPEAT(1'b0)) dut0 (
        .sck(sck), .reset(reset), .ws(ws), .in_L(in_L), .in_R(in_R),
        .in_valid(in_valid), .in_ready(in_ready0), .sd(sd0),
        .frame_start(frame_start0), .underrun(underrun0),
        .underrun_count(underrun_count0)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One sck cycle: ws changes on the falling edge, then the bit launched on
    // that same edge is captured into the history.
    task automatic step(input logic w);
        @(negedge sck);
        ws = w;
        #1;
        hist   = {hist[62:0], sd};
        hist0  = {hist0[62:0], sd0};
        fs_cnt += int'(frame_start);
        ur_cnt += int'(underrun);
    endtask

    task automatic slot(input logic w, input int n);
        repeat (n) step(w);
    endtask

    initial begin
        reset = 1'b1; ws = 1'b1; in_valid = 1'b0; in_L = '0; in_R = '0;
        #12;
        check("reset_sd", 64'(sd), 64'(1'b0));
        check("reset_in_ready", 64'(in_ready), 64'(1'b1));
        check("reset_count", 64'(underrun_count), 64'(16'h0));
        check("reset_frame_start", 64'(frame_start), 64'(1'b0));
        @(negedge sck);
        reset = 1'b0;

        // Pair A accepted while unsynchronised
        slot(1'b1, 3);
        in_L = A_L; in_R = A_R; in_valid = 1'b1;
        @(posedge sck); #1;
        check("presync_accept_ready", 64'(in_ready), 64'(1'b0));
        in_valid = 1'b0; in_L = '0; in_R = '0;
        slot(1'b1, 3);
        check("presync_sd_zero", hist, 64'h0);
        check("presync_no_pulses", 64'(fs_cnt + ur_cnt), 64'(0));

        // Frame 1: pair A
        slot(1'b0, 1);
        @(posedge sck); #1;
        check("f1_frame_start", 64'(frame_start), 64'(1'b1));
        check("f1_no_underrun", 64'(underrun), 64'(1'b0));
        check("f1_ready_after_xfer", 64'(in_ready), 64'(1'b1));
        slot(1'b0, 31); slot(1'b1, 1);
        check("f1_left", 64'(hist[31:0]), 64'(A_L));
        check("f1_left_zf", 64'(hist0[31:0]), 64'(A_L));
        slot(1'b1, 31); slot(1'b0, 1);
        check("f1_right", 64'(hist[31:0]), 64'(A_R));
        check("f1_fs_once", 64'(fs_cnt), 64'(1));
        check("f1_ur_none", 64'(ur_cnt), 64'(0));

        // Frame 2: underrun, repeat vs zero fill
        @(posedge sck); #1;
        check("f2_underrun", 64'(underrun), 64'(1'b1));
        check("f2_frame_start", 64'(frame_start), 64'(1'b1));
        check("f2_count", 64'(underrun_count), 64'(16'd1));
        check("f2_count_zf", 64'(underrun_count0), 64'(16'd1));
        slot(1'b0, 31); slot(1'b1, 1);
        check("f2_left_repeat", 64'(hist[31:0]), 64'(A_L));
        check("f2_left_zf", 64'(hist0[31:0]), 64'h0);
        slot(1'b1, 31);

        // Frame 3: accept on the same edge as an underrun left edge
        slot(1'b0, 1);
        in_L = P1L; in_R = P1R; in_valid = 1'b1;
        check("f2_right_repeat", 64'(hist[31:0]), 64'(A_R));
        check("f2_right_zf", 64'(hist0[31:0]), 64'h0);
        @(posedge sck); #1;
        check("f3_underrun", 64'(underrun), 64'(1'b1));
        check("f3_simul_accept", 64'(in_ready), 64'(1'b0));
        check("f3_count", 64'(underrun_count), 64'(16'd2));
        in_L = P2L; in_R = P2R;
        slot(1'b0, 31); slot(1'b1, 1);
        check("f3_left_repeat", 64'(hist[31:0]), 64'(A_L));
        check("f3_p2_waiting", 64'(in_ready), 64'(1'b0));
        slot(1'b1, 31);

        // Frame 4: P1 out, P2 accepted one cycle after the left edge
        slot(1'b0, 1);
        check("f3_right_repeat", 64'(hist[31:0]), 64'(A_R));
        check("f4_ready_pre_edge", 64'(in_ready), 64'(1'b0));
        @(posedge sck); #1;
        check("f4_ready_rise", 64'(in_ready), 64'(1'b1));
        check("f4_frame_start", 64'(frame_start), 64'(1'b1));
        check("f4_no_underrun", 64'(underrun), 64'(1'b0));
        slot(1'b0, 1);
        @(posedge sck); #1;
        check("f4_p2_accept", 64'(in_ready), 64'(1'b0));
        in_L = P3L; in_R = P3R;
        slot(1'b0, 30); slot(1'b1, 1);
        check("f4_left_p1", 64'(hist[31:0]), 64'(P1L));
        check("f4_left_p1_zf", 64'(hist0[31:0]), 64'(P1L));
        slot(1'b1, 31);

        // Frame 5: P2 out, P3 accepted
        slot(1'b0, 1);
        check("f4_right_p1", 64'(hist[31:0]), 64'(P1R));
        check("f4_right_p1_zf", 64'(hist0[31:0]), 64'(P1R));
        @(posedge sck); #1;
        check("f5_ready_rise", 64'(in_ready), 64'(1'b1));
        slot(1'b0, 1);
        @(posedge sck); #1;
        check("f5_p3_accept", 64'(in_ready), 64'(1'b0));
        in_valid = 1'b0; in_L = '0; in_R = '0;
        slot(1'b0, 30); slot(1'b1, 1);
        check("f5_left_p2", 64'(hist[31:0]), 64'(P2L));
        slot(1'b1, 31);

        // Frame 6: P3 out
        slot(1'b0, 1);
        check("f5_right_p2", 64'(hist[31:0]), 64'(P2R));
        slot(1'b0, 31); slot(1'b1, 1);
        check("f6_left_p3", 64'(hist[31:0]), 64'(P3L));
        slot(1'b1, 31);

        // Frame 7: 48-sck left slot, 24-sck right slot
        slot(1'b0, 1);
        check("f6_right_p3", 64'(hist[31:0]), 64'(P3R));
        check("f6_fs_total", 64'(fs_cnt), 64'(6));
        check("f6_ur_total", 64'(ur_cnt), 64'(2));
        slot(1'b0, 47); slot(1'b1, 1);
        check("long_slot_pad", 64'(hist[47:0]), 64'({P3L, 16'h0}));
        slot(1'b1, 23); slot(1'b0, 1);
        check("short_slot_trunc", 64'(hist[23:0]), 64'(P3R[31:8]));
        slot(1'b0, 31); slot(1'b1, 1);
        check("after_short_msb", 64'(hist[31:0]), 64'(P3L));
        slot(1'b1, 31);

        // Frame 9: reset asserted while bit 10 of the left word is on sd
        slot(1'b0, 1);
        check("f8_right_p3", 64'(hist[31:0]), 64'(P3R));
        slot(1'b0, 11);
        check("midword_bit10", 64'(sd), 64'(1'b1));
        check("midword_count", 64'(underrun_count), 64'(16'd5));
        #2 reset = 1'b1;
        #1;
        check("midreset_sd", 64'(sd), 64'(1'b0));
        check("midreset_count", 64'(underrun_count), 64'(16'h0));
        check("midreset_ready", 64'(in_ready), 64'(1'b1));
        ws = 1'b1;
        @(negedge sck);
        reset = 1'b0;
        hist = '0; hist0 = '0;
        slot(1'b1, 10);
        check("post_reset_quiet", hist, 64'h0);
        slot(1'b0, 1);
        @(posedge sck); #1;
        check("post_reset_underrun", 64'(underrun), 64'(1'b1));
        check("post_reset_count", 64'(underrun_count), 64'(16'd1));
        slot(1'b0, 31); slot(1'b1, 1);
        check("post_reset_zero_word", hist, 64'h0);
        slot(1'b1, 31);

        // Saturation: preload near the top, then run short frames
        force dut.underrun_count = 16'hFFFC;
        #1;
        release dut.underrun_count;
        step(1'b0); step(1'b1);
        check("sat_step1", 64'(underrun_count), 64'(16'hFFFD));
        repeat (2) begin step(1'b0); step(1'b1); end
        check("sat_reach", 64'(underrun_count), 64'(16'hFFFF));
        repeat (2) begin step(1'b0); step(1'b1); end
        check("sat_hold", 64'(underrun_count), 64'(16'hFFFF));
        check("sat_zf_count", 64'(underrun_count0), 64'(16'd6));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2s_transmitter.md
# i2s_transmitter

Serial output stage of the audio path. It accepts processed stereo sample pairs from the EQ over a valid/ready handshake and serializes them MSB-first onto an I2S data line, using the same `sck`/`ws` pair that clocks the I2S receiver. It is the output-side counterpart of the receiver and drives the DAC. It runs entirely in the `sck` domain, buffers one pending pair, and repeats or zero-fills on underrun.

## Interface
- `SR_WIDTH`, 32: sample word width in bits (≥ 2).
- `UNDERRUN_REPEAT`, 1: on underrun, 1 = resend the last pair; 0 = send zeros.
- `sck` input 1: serial bit clock, the only clock. Logic uses the rising edge; `sd` launches on the falling edge.
- `reset` input 1: asynchronous, active-high.
- `ws` input 1: word select, driven externally and changing on falling `sck`. 0 = left slot, 1 = right slot.
- `in_L` input SR_WIDTH: left sample, two's complement.
- `in_R` input SR_WIDTH: right sample.
- `in_valid` input 1: `in_L`/`in_R` hold a valid pair.
- `in_ready` output 1: the pending buffer is empty. Combinational, equal to ~pend_full.
- `sd` output 1: serial data, registered on falling `sck`.
- `frame_start` output 1: one-cycle pulse on each accepted left-slot start.
- `underrun` output 1: one-cycle pulse when a left slot starts with no pending pair.
- `underrun_count` output 16: saturating count of underruns.

## Operation
- Edge detect: `ws_d` is `ws` registered on rising `sck`.
  - Left edge: `ws_d`=1 and `ws`=0.
  - Right edge: `ws_d`=0 and `ws`=1.
- Handshake: a pair is accepted on a rising edge where `in_valid`=1 and `in_ready`=1. Accepting writes `pend_L`/`pend_R` and sets `pend_full`.
- Sync state (`synced`, reset 0):
  - Set on the first left edge.
  - Before `synced`=1, `sd` stays 0, no shift-register load occurs, and `underrun`/`frame_start` never pulse. The handshake is still active, so one pair may be pending.
- Left edge with `synced` or becoming synced:
  - If `pend_full`=1: `act_L`←`pend_L`, `act_R`←`pend_R`, shift register←`pend_L`, clear `pend_full`, pulse `frame_start`.
  - Otherwise: pulse `underrun` and increment `underrun_count` (saturating at 0xFFFF). The shift register loads `act_L` if `UNDERRUN_REPEAT`=1, else 0. `act_*` are zeroed when `UNDERRUN_REPEAT`=0. `frame_start` still pulses.
- Right edge with `synced`: the shift register loads `act_R`.
- Accept on the same edge as a left-edge transfer: the transfer uses the old pending contents, and the new pair is written to pending. Net `pend_full`=1.
- Non-edge rising `sck`: the shift register shifts left by 1 and fills with 0.
- Falling `sck`: `sd` ← shift-register MSB.
- Slot longer than SR_WIDTH: `sd`=0 after the LSB (zero pad).
- Slot shorter than SR_WIDTH: the remaining LSBs are dropped at the next `ws` edge.
- Reset (asynchronous, any time including mid-word), all state cleared:
  - `sd`=0, shift register=0, `ws_d`=0, `act_*`=0, `pend_*`=0, `pend_full`=0, `synced`=0.
  - `frame_start`=0, `underrun`=0, `underrun_count`=0; `in_ready`=1.
  - After release, output resumes only from the next left edge.

## Timing
- `ws` changes on falling edge n−1. Rising edge k (the first after it) detects the edge and loads the word.
- The MSB appears on `sd` at the falling edge after rising edge k. The receiver samples it at rising edge k+1, giving the I2S one-bit delay.
- Bit i (0 = MSB) is valid from the falling edge after rising edge k+i until the falling edge after rising edge k+i+1.
- The accept-to-`in_ready` high latency is one left-edge boundary. Maximum throughput is one pair per frame.
- `frame_start`/`underrun` are asserted for the rising-edge cycle after edge k, coincident with the registered load.

## Test plan
- Reset, then 64-sck frames (32 per slot) with `in_L`=0xA5A5_0001 and `in_R`=0x8000_FFFF accepted before the first left edge. `sd` must replay 0xA5A5_0001 MSB-first starting one sck after the `ws` fall, then 0x8000_FFFF after the `ws` rise. `frame_start` pulses once; `underrun` stays 0.
- No input on the second frame with `UNDERRUN_REPEAT`=1: the same pair is resent, `underrun` pulses and `underrun_count`=1. With `UNDERRUN_REPEAT`=0: `sd` stays all-zero.
- Hold `in_valid`=1 continuously: exactly one accept per frame. `in_ready` falls after each accept and rises on the left edge. Checking the pair sequence 1, 2, 3 confirms no loss or duplication, including the simultaneous accept-on-left-edge case.
- 32-bit word in a 48-sck slot: 32 data bits followed by 16 zeros. 32-bit word in a 24-sck slot: the top 24 bits only, with the next slot's MSB on time.
- Assert `reset` mid-word (bit 10 of left): `sd` goes to 0 immediately and `underrun_count` reads 0. After release with `ws`=1 (no left edge yet), `sd` stays 0 until the next left edge.
- Force 65,540 underruns: `underrun_count` saturates at 0xFFFF.
